// File: rtl/ama_riscv_imem_loader_if.sv
// rtl/ama_riscv_imem_loader_if.sv - IMEM loader bus: byte stream, core store path, IMEM port, status
interface ama_riscv_imem_loader_if #(
    parameter int DEPTH_W = 14
);
    logic               load_start;
    logic               rx_valid;
    logic [7:0]         rx_data;
    logic               rx_ready;
    logic [3:0]         core_we;
    logic [DEPTH_W-1:0] core_addr;
    logic [31:0]        core_wdata;
    logic               core_wr_ready;
    logic               core_stall;
    logic               imem_ena;
    logic [3:0]         imem_wea;
    logic [DEPTH_W-1:0] imem_addra;
    logic [31:0]        imem_dina;
    logic               load_busy;
    logic               load_done;
    logic               load_err;
    logic [31:0]        load_csum;

    modport slave (
        input  load_start, rx_valid, rx_data, core_we, core_addr, core_wdata,
        output rx_ready, core_wr_ready, core_stall,
        output imem_ena, imem_wea, imem_addra, imem_dina,
        output load_busy, load_done, load_err, load_csum
    );

    modport master (
        output load_start, rx_valid, rx_data, core_we, core_addr, core_wdata,
        input  rx_ready, core_wr_ready, core_stall,
        input  imem_ena, imem_wea, imem_addra, imem_dina,
        input  load_busy, load_done, load_err, load_csum
    );
endinterface

// File: rtl/ama_riscv_imem_loader.sv
// rtl/ama_riscv_imem_loader.sv - IMEM write-port arbiter between core stores and a byte-stream program loader
module ama_riscv_imem_loader #(
    parameter int DEPTH_W = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    ama_riscv_imem_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CNT,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [31:0]        MAX_CNT = 32'(1) << DEPTH_W;
    localparam logic [DEPTH_W-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_W:0]   REM_ONE = 1;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_byte_cnt;
    logic [23:0]        r_shift;
    logic               r_base_misal;
    logic [DEPTH_W-1:0] r_base_ptr;
    logic [DEPTH_W-1:0] r_ptr;
    logic [DEPTH_W:0]   r_remain;
    logic               r_err;
    logic [31:0]        r_csum;
    logic               r_ena;
    logic [3:0]         r_wea;
    logic [DEPTH_W-1:0] r_addra;
    logic [31:0]        r_dina;

    logic        w_rx_ready;
    logic        w_core_rdy;
    logic        w_busy;
    logic        w_done;
    logic        w_rx_fire;
    logic        w_last_byte;
    logic [31:0] w_word;
    logic        w_hdr_bad;
    logic        w_core_fire;
    logic        w_data_write;

    // Bytes enter at the top and shift down, so the 4th byte completes a little-endian word.
    assign w_word       = {bus.rx_data, r_shift};
    assign w_rx_fire    = bus.rx_valid & bus.rx_ready;
    assign w_last_byte  = w_rx_fire & (r_byte_cnt == 2'd3);
    assign w_hdr_bad    = r_base_misal | (w_word > MAX_CNT);
    assign w_core_fire  = (r_state == S_IDLE) & ~rst & (|bus.core_we);
    assign w_data_write = (r_state == S_DATA) & w_last_byte;

    always_comb begin
        w_next     = r_state;
        w_rx_ready = 1'b0;
        w_core_rdy = 1'b0;
        w_busy     = 1'b1;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy     = 1'b0;
                w_core_rdy = 1'b1;
                if (bus.load_start) w_next = S_ADDR;
            end
            S_ADDR: begin
                w_rx_ready = 1'b1;
                if (w_last_byte) w_next = S_CNT;
            end
            S_CNT: begin
                w_rx_ready = 1'b1;
                if (w_last_byte) begin
                    if (w_hdr_bad || (w_word == 32'd0)) w_next = S_DONE;
                    else                                w_next = S_DATA;
                end
            end
            S_DATA: begin
                w_rx_ready = 1'b1;
                if (w_last_byte && (r_remain == REM_ONE)) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Combinational status is forced low during reset so nothing looks ready mid-reset.
    assign bus.rx_ready      = w_rx_ready & ~rst;
    assign bus.core_wr_ready = w_core_rdy & ~rst;
    assign bus.core_stall    = w_busy & ~rst;
    assign bus.load_busy     = w_busy & ~rst;
    assign bus.load_done     = w_done & ~rst;
    assign bus.load_err      = r_err;
    assign bus.load_csum     = r_csum;
    assign bus.imem_ena      = r_ena;
    assign bus.imem_wea      = r_wea;
    assign bus.imem_addra    = r_addra;
    assign bus.imem_dina     = r_dina;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_byte_cnt   <= 2'd0;
            r_shift      <= 24'd0;
            r_base_misal <= 1'b0;
            r_base_ptr   <= '0;
            r_ptr        <= '0;
            r_remain     <= '0;
            r_err        <= 1'b0;
            r_csum       <= 32'd0;
            r_ena        <= 1'b0;
            r_wea        <= 4'd0;
            r_addra      <= '0;
            r_dina       <= 32'd0;
        end else begin
            r_state <= w_next;
            r_ena   <= 1'b0;
            r_wea   <= 4'd0;

            if ((r_state == S_IDLE) && bus.load_start) begin
                r_err      <= 1'b0;
                r_csum     <= 32'd0;
                r_byte_cnt <= 2'd0;
            end

            if (w_rx_fire) begin
                r_shift    <= w_word[31:8];
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end

            if ((r_state == S_ADDR) && w_last_byte) begin
                r_base_misal <= (w_word[1:0] != 2'd0);
                r_base_ptr   <= w_word[DEPTH_W+1:2];
            end

            if ((r_state == S_CNT) && w_last_byte) begin
                if (w_hdr_bad) r_err <= 1'b1;
                r_ptr    <= r_base_ptr;
                r_remain <= w_word[DEPTH_W:0];
            end

            // Core and loader writes are exclusive by state; at most one fires per cycle.
            if (w_core_fire) begin
                r_ena   <= 1'b1;
                r_wea   <= bus.core_we;
                r_addra <= bus.core_addr;
                r_dina  <= bus.core_wdata;
            end else if (w_data_write) begin
                r_ena    <= 1'b1;
                r_wea    <= 4'hF;
                r_addra  <= r_ptr;
                r_dina   <= w_word;
                r_csum   <= r_csum ^ w_word;
                r_ptr    <= r_ptr + PTR_ONE;
                r_remain <= r_remain - REM_ONE;
            end
        end
    end
endmodule

// File: tb/tb_ama_riscv_imem_loader.sv
// tb/tb_ama_riscv_imem_loader.sv - scoreboard bench for ama_riscv_imem_loader
module tb_ama_riscv_imem_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ama_riscv_imem_loader_if #(.DEPTH_W(14)) bus();

    ama_riscv_imem_loader #(.DEPTH_W(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [49:0] exp_q[$];
    logic [31:0] payload[$];
    logic [31:0] m_csum;
    logic        m_err;
    bit          gaps_on   = 1'b0;
    bit          hold_core = 1'b0;
    logic [49:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Expected IMEM writes: {wea, addr, data}
    always @(negedge clk) begin
        if (bus.imem_ena === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL imem_unexpected: got write @0x%04h data 0x%08h wea %b expected none",
                         bus.imem_addra, bus.imem_dina, bus.imem_wea);
            end else begin
                mon_e = exp_q.pop_front();
                chk("imem_wea",   32'(bus.imem_wea),   32'(mon_e[49:46]));
                chk("imem_addra", 32'(bus.imem_addra), 32'(mon_e[45:32]));
                chk("imem_dina",  bus.imem_dina,       mon_e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ena"},     32'(bus.imem_ena),   32'd0);
        chk({tag, "_wea"},     32'(bus.imem_wea),   32'd0);
        chk({tag, "_addra"},   32'(bus.imem_addra), 32'd0);
        chk({tag, "_dina"},    bus.imem_dina,       32'd0);
        chk({tag, "_rxrdy"},   32'(bus.rx_ready),   32'd0);
        chk({tag, "_stall"},   32'(bus.core_stall), 32'd0);
        chk({tag, "_busy"},    32'(bus.load_busy),  32'd0);
        chk({tag, "_done"},    32'(bus.load_done),  32'd0);
        chk({tag, "_err"},     32'(bus.load_err),   32'd0);
        chk({tag, "_csum"},    bus.load_csum,       32'd0);
        chk({tag, "_corerdy"}, 32'(bus.core_wr_ready), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.load_start = 1'b0;
        bus.core_we = 4'd0;
        tick();
        tick();
        check_reset_vals(tag);
        rst = 1'b0;
        #1;
        chk({tag, "_corerdy_after"}, 32'(bus.core_wr_ready), 32'd1);
    endtask

    task automatic core_write(input logic [3:0] we, input logic [13:0] addr, input logic [31:0] data);
        bus.core_we    = we;
        bus.core_addr  = addr;
        bus.core_wdata = data;
        exp_q.push_back({we, addr, data});
        #1;
        chk("core_wr_ready_idle", 32'(bus.core_wr_ready), 32'd1);
        tick();
        bus.core_we = 4'd0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (gaps_on) repeat ($urandom_range(0, 2)) tick();
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        #1;
        chk("rx_ready", 32'(bus.rx_ready), 32'd1);
        if (hold_core) begin
            chk("core_wr_ready_busy", 32'(bus.core_wr_ready), 32'd0);
            chk("core_stall_busy",    32'(bus.core_stall),    32'd1);
        end
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(8'(w >> (8 * k)));
    endtask

    // Reference: expected writes follow directly from base/count and the payload words.
    task automatic run_load(input logic [31:0] base, input logic [31:0] cnt, input bit core_during);
        if (core_during) begin
            bus.core_we    = 4'h3;
            bus.core_addr  = 14'h0123;
            bus.core_wdata = 32'h55AA55AA;
            exp_q.push_back({4'h3, 14'h0123, 32'h55AA55AA});
        end
        m_err  = (base[1:0] != 2'd0) || (cnt > 32'd16384);
        m_csum = 32'd0;
        if (!m_err) begin
            for (int i = 0; i < int'(cnt); i++) begin
                exp_q.push_back({4'hF, 14'((base >> 2) + 32'(i)), payload[i]});
                m_csum ^= payload[i];
            end
        end
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        chk("start_busy", 32'(bus.load_busy), 32'd1);
        chk("start_err",  32'(bus.load_err),  32'd0);
        chk("start_csum", bus.load_csum,      32'd0);
        if (core_during) begin
            bus.core_we    = 4'hF;
            bus.core_addr  = 14'h0007;
            bus.core_wdata = 32'hBAD0BAD0;
            hold_core      = 1'b1;
        end
        send_word(base);
        send_word(cnt);
        if (!m_err) for (int i = 0; i < int'(cnt); i++) send_word(payload[i]);
        finish_load();
        payload.delete();
    endtask

    task automatic finish_load();
        bit seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.load_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("load_done_seen", 32'(seen), 32'd1);
        if (hold_core) begin
            chk("core_wr_ready_done", 32'(bus.core_wr_ready), 32'd0);
            bus.core_we = 4'd0;
            hold_core   = 1'b0;
        end
        chk("load_err",  32'(bus.load_err), 32'(m_err));
        chk("load_csum", bus.load_csum,     m_csum);
        tick();
        chk("done_pulse_end", 32'(bus.load_done),     32'd0);
        chk("idle_busy",      32'(bus.load_busy),     32'd0);
        chk("idle_corerdy",   32'(bus.core_wr_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] base;
        logic [31:0] cnt;
        bus.load_start = 1'b0;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'd0;
        bus.core_we    = 4'd0;
        bus.core_addr  = 14'd0;
        bus.core_wdata = 32'd0;

        do_reset("reset");

        core_write(4'b0101, 14'h0010, 32'hA1B2C3D4);
        tick();

        payload.push_back(32'h12345678);
        payload.push_back(32'hDEADBEEF);
        run_load(32'h00000100, 32'd2, 1'b0);
        chk("two_word_csum", m_csum, 32'hCC99E897);

        payload.push_back($urandom);
        payload.push_back($urandom);
        run_load(32'h0000FFFC, 32'd2, 1'b0);

        run_load(32'h00000102, 32'd1, 1'b0);
        run_load(32'h00000000, 32'h00004001, 1'b0);
        run_load(32'h00000040, 32'd0, 1'b0);

        payload.push_back($urandom);
        payload.push_back($urandom);
        run_load(32'h00000400, 32'd2, 1'b1);

        for (int r = 0; r < 8; r++) begin
            gaps_on = ($urandom_range(0, 1) == 1);
            base = (r == 3) ? 32'h0000FFF8 : ($urandom & 32'hFFFFFFFC);
            cnt  = 32'($urandom_range(1, 4));
            for (int i = 0; i < int'(cnt); i++) payload.push_back($urandom);
            run_load(base, cnt, ($urandom_range(0, 3) == 0));
            core_write(4'($urandom_range(1, 15)), 14'($urandom), $urandom);
        end
        gaps_on = 1'b0;

        exp_q.push_back({4'hF, 14'h0080, 32'h0A0B0C0D});
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        send_word(32'h00000200);
        send_word(32'd3);
        send_word(32'h0A0B0C0D);
        send_byte(8'h11);
        send_byte(8'h22);
        do_reset("midload");
        chk("midload_busy", 32'(bus.load_busy), 32'd0);

        repeat (3) tick();
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ama_riscv_imem_loader.md
# ama_riscv_imem_loader

Write-port controller for the 16K x 32 instruction memory. Shares the IMEM write port between the core's store path and a byte-stream program loader (UART RX side). The loader parses a little-endian header (base address, word count), assembles payload bytes into words, writes them sequentially, and stalls the core for the duration of the load.

## Interface

Parameters:
- `DEPTH_W`, 14: IMEM word-address width (16384 words).

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `load_start`  in  1  single-cycle pulse; starts a load; honoured only in IDLE.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  loader accepts a byte; transfer when `rx_valid & rx_ready`.
- `core_we`  in  4  core byte-write enables; nonzero = write request.
- `core_addr`  in  14  core word address.
- `core_wdata`  in  32  core write data.
- `core_wr_ready`  out  1  core write accepted this cycle when `core_we != 0`.
- `core_stall`  out  1  high while a load is in progress.
- `imem_ena`  out  1  IMEM port-A enable (registered).
- `imem_wea`  out  4  IMEM byte write enables (registered).
- `imem_addra`  out  14  IMEM word address (registered).
- `imem_dina`  out  32  IMEM write data (registered).
- `load_busy`  out  1  state != IDLE.
- `load_done`  out  1  one-cycle pulse at load end (success or error).
- `load_err`  out  1  sticky error; cleared by `load_start` or `rst`.
- `load_csum`  out  32  XOR of all words written by the current/last load; cleared by `load_start`.

## Operation

- FSM states: IDLE, ADDR, CNT, DATA, DONE.
- IDLE: `core_wr_ready=1`, `rx_ready=0`. `load_start` -> ADDR; clears `load_err`, `load_csum`, byte counter.
- ADDR: `rx_ready=1`; 4 bytes, LSB first, form 32-bit byte address `base`. After the 4th byte -> CNT.
- CNT: `rx_ready=1`; 4 bytes, LSB first, form `count` (words). After the 4th byte:
  - `base[1:0] != 0` or `count > 16384` -> set `load_err`, go to DONE, no writes.
  - `count == 0` -> DONE, no writes.
  - otherwise -> DATA; write pointer = `base[15:2]`; remaining = `count`.
- DATA: `rx_ready=1`; bytes assembled little-endian (byte 0 -> bits 7:0). On the 4th byte: issue a full-word write (`wea=4'hF`) at the pointer, XOR the word into `load_csum`, increment the pointer mod 2^14 (wraps 16383 -> 0), decrement remaining. Remaining reaching 0 -> DONE.
- DONE: `load_done=1` for one cycle, then IDLE.
- Core path: in IDLE, `core_we != 0` forwards `core_we`, `core_addr`, `core_wdata` to the IMEM port. In all other states `core_wr_ready=0`, `core_stall=1`, and core requests are not registered.
- IMEM port outputs are registered and idle (`ena=0`, `wea=0`) in any cycle with no accepted write. Only one source can drive a cycle's write because the two sources are exclusive by state.
- Counters: 2-bit byte counter and 15-bit remaining-word counter, both of fixed width with no overflow.

## Timing

- Reset values: `imem_ena=0`, `imem_wea=0`, `imem_addra=0`, `imem_dina=0`, `rx_ready=0`, `core_stall=0`, `load_busy=0`, `load_done=0`, `load_err=0`, `load_csum=0`, state IDLE. `core_wr_ready=0` while `rst` is high and 1 in the first IDLE cycle after reset.
- Core write accepted in cycle N appears on the IMEM port in cycle N+1, for exactly one cycle.
- Loader: the 4th data byte accepted in cycle N gives an IMEM write in cycle N+1. The loader never backpressures, so one byte per cycle is sustained. Peak rate is 1 word per 4 cycles.
- After the final write's byte (cycle N): DONE in N+1, `load_done` in N+1, IDLE and `core_wr_ready=1` in N+2.
- `load_start` together with a core write in IDLE: the core write is accepted, and ADDR starts next cycle.
- `load_start` outside IDLE is ignored.
- `rst` mid-load: synchronous return to IDLE. The partial word is discarded. A write registered in the same cycle is squashed (`imem_ena=0` next cycle). Words already written remain in IMEM.

## Test plan

- Core write in IDLE: `core_we=4'b0101`, addr 0x0010, data 0xA1B2C3D4 -> next cycle `imem_ena=1`, `wea=0101`, `addra=0x0010`, `dina=0xA1B2C3D4`.
- Load 2 words: bytes 00 01 00 00 | 02 00 00 00 | 78 56 34 12 | EF BE AD DE -> writes 0x12345678 @0x0040, then 0xDEADBEEF @0x0041. `load_csum=0xCC99E897`, `load_done` pulses, `load_err=0`.
- Core write during load: `core_we=4'hF` held while busy -> `core_wr_ready=0`, `core_stall=1`, no IMEM write from core.
- Wrap: base 0x0000FFFC, count 2 -> writes @0x3FFF, then @0x0000.
- Errors: base 0x00000102 -> `load_err=1`, `load_done`, zero writes. Count 0x4001 -> same. Next `load_start` clears `load_err`.
- `rst` after 6 payload bytes of a 3-word load -> exactly one IMEM write occurred, state IDLE, all outputs at reset values.
